// File: rtl/elevator_request_scheduler.sv
// Three-floor collective request scheduler: button capture, direction-preserving dispatch,
// door sequencing and travel watchdog. Define ELEV_IDLE_HOME_EN to return the idle car to floor 1.
module elevator_request_scheduler #(
    parameter int TMO_W      = 8,
    parameter int TRAVEL_TMO = 200,
    parameter int HOME_DLY   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       FB1,
    input  logic       FB2,
    input  logic       FB3,
    input  logic       CALL1,
    input  logic       CALL2,
    input  logic       CALL3,
    input  logic [1:0] car_floor,
    input  logic       arrive,
    input  logic       tgt_ack,
    input  logic       door_done,
    output logic [1:0] tgt_floor,
    output logic       tgt_valid,
    output logic       door_req,
    output logic       UD,
    output logic [2:0] pend,
    output logic       fault
);

    typedef enum logic [2:0] {IDLE, DISPATCH, TRAVEL, SERVICE, FAULT} state_t;

    state_t           state, state_n;
    logic [2:0]       fb_s1, fb_s2, call_s1, call_s2;
    logic [2:0]       req_set, req_clr, floor_bit;
    logic             here, above, below, up_pref, go_up, go_dn, home_fire;
    logic [TMO_W-1:0] wd, wd_n;
    logic [1:0]       tgt_n;
    logic             ud_n;

    // Buttons are active-low, so the synchronizers idle high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_s1   <= '1;
            fb_s2   <= '1;
            call_s1 <= '1;
            call_s2 <= '1;
        end else begin
            fb_s1   <= {FB3, FB2, FB1};
            fb_s2   <= fb_s1;
            call_s1 <= {CALL3, CALL2, CALL1};
            call_s2 <= call_s1;
        end
    end

    assign req_set = ~fb_s2 | ~call_s2;

    always_comb begin
        floor_bit = '0;
        above     = 1'b0;
        below     = 1'b0;
        case (car_floor)
            2'd1: begin
                floor_bit = 3'b001;
                above     = |pend[2:1];
            end
            2'd2: begin
                floor_bit = 3'b010;
                above     = pend[2];
                below     = pend[0];
            end
            2'd3: begin
                floor_bit = 3'b100;
                below     = |pend[1:0];
            end
            default: ;
        endcase
    end

    // Keep the current direction while work remains that way; the end floors force it.
    assign here    = |(pend & floor_bit);
    assign up_pref = (car_floor == 2'd1) | (UD & (car_floor != 2'd3));
    assign go_up   = above & (up_pref | ~below);
    assign go_dn   = below & ~go_up;

`ifdef ELEV_IDLE_HOME_EN
    localparam int HW = $clog2(HOME_DLY + 1);
    logic [HW-1:0] hcnt;
    logic          hcnt_run;

    assign hcnt_run  = (state == IDLE) && (pend == '0) && (car_floor > 2'd1);
    assign home_fire = hcnt_run && (hcnt == HW'(HOME_DLY - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     hcnt <= '0;
        else if (!hcnt_run || home_fire) hcnt <= '0;
        else                           hcnt <= hcnt + 1'b1;
    end
`else
    assign home_fire = 1'b0;
`endif

    always_comb begin
        state_n = state;
        tgt_n   = tgt_floor;
        ud_n    = UD;
        wd_n    = wd;
        req_clr = '0;
        case (state)
            IDLE: begin
                if (car_floor == 2'd0) begin
                    state_n = FAULT;
                end else if (here) begin
                    state_n = SERVICE;
                end else if (go_up) begin
                    ud_n    = 1'b1;
                    tgt_n   = car_floor + 2'd1;
                    state_n = DISPATCH;
                end else if (go_dn || home_fire) begin
                    ud_n    = 1'b0;
                    tgt_n   = car_floor - 2'd1;
                    state_n = DISPATCH;
                end
            end
            DISPATCH: begin
                if (tgt_ack) begin
                    state_n = TRAVEL;
                    wd_n    = '0;
                end
            end
            TRAVEL: begin
                if (arrive) begin
                    if (car_floor == tgt_floor) state_n = IDLE;
                    else                        state_n = FAULT;
                end else if (wd == TMO_W'(TRAVEL_TMO - 1)) begin
                    state_n = FAULT;
                end else begin
                    wd_n = wd + 1'b1;
                end
            end
            SERVICE: begin
                if (door_done) begin
                    req_clr = floor_bit;
                    state_n = IDLE;
                end
            end
            FAULT:   ;
            default: state_n = FAULT;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tgt_floor <= 2'd1;
            UD        <= 1'b1;
            tgt_valid <= 1'b0;
            door_req  <= 1'b0;
            fault     <= 1'b0;
            pend      <= '0;
            wd        <= '0;
        end else begin
            state     <= state_n;
            tgt_floor <= tgt_n;
            UD        <= ud_n;
            tgt_valid <= (state_n == DISPATCH);
            door_req  <= (state_n == SERVICE);
            fault     <= (state_n == FAULT);
            pend      <= (pend | req_set) & ~req_clr;
            wd        <= wd_n;
        end
    end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed scoreboard bench for elevator_request_scheduler with a simple car/door responder.
module tb_elevator_request_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       FB1, FB2, FB3, CALL1, CALL2, CALL3;
    logic [1:0] car_floor;
    logic       arrive, tgt_ack, door_done;
    logic [1:0] tgt_floor;
    logic       tgt_valid, door_req, UD, fault;
    logic [2:0] pend;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        bit         door;
        logic [1:0] floor;
        bit         chk_ud;
        logic       ud;
    } ev_t;

    ev_t sb[$];

    elevator_request_scheduler #(
        .TMO_W(8),
        .TRAVEL_TMO(200),
        .HOME_DLY(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .FB1(FB1),
        .FB2(FB2),
        .FB3(FB3),
        .CALL1(CALL1),
        .CALL2(CALL2),
        .CALL3(CALL3),
        .car_floor(car_floor),
        .arrive(arrive),
        .tgt_ack(tgt_ack),
        .door_done(door_done),
        .tgt_floor(tgt_floor),
        .tgt_valid(tgt_valid),
        .door_req(door_req),
        .UD(UD),
        .pend(pend),
        .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: run did not complete, required completion within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_ev(input bit door, input logic [1:0] f, input bit c, input logic u);
        ev_t e;
        e.door   = door;
        e.floor  = f;
        e.chk_ud = c;
        e.ud     = u;
        sb.push_back(e);
    endfunction

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_tgt_floor"}, tgt_floor, 2'd1);
        chk({pfx, "_tgt_valid"}, tgt_valid, 1'b0);
        chk({pfx, "_door_req"},  door_req,  1'b0);
        chk({pfx, "_UD"},        UD,        1'b1);
        chk({pfx, "_pend"},      pend,      3'b000);
        chk({pfx, "_fault"},     fault,     1'b0);
    endtask

    task automatic do_reset(input logic [1:0] cf);
        @(negedge clk);
        reset     = 1'b1;
        car_floor = cf;
        tick();
        reset     = 1'b0;
    endtask

    // mode 0: normal arrival, 1: never arrive, 2: arrive at the wrong floor
    task automatic expect_next(input int mode, input bit press_fb2);
        ev_t e;
        int  n;
        int  idx;
        n = 0;
        while (!(tgt_valid || door_req) && n < 120) begin
            tick();
            n++;
        end
        chk("event_seen", tgt_valid | door_req, 1'b1);
        if (!(tgt_valid || door_req)) return;
        chk("sb_nonempty", sb.size() > 0, 1'b1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("event_kind", door_req, e.door);
        if (e.chk_ud) chk("event_UD", UD, e.ud);
        if (!e.door) begin
            chk("tgt_floor", tgt_floor, e.floor);
            tick();
            chk("tgt_hold", {tgt_valid, tgt_floor}, {1'b1, e.floor});
            tgt_ack = 1'b1;
            tick();
            tgt_ack = 1'b0;
            chk("valid_drop", tgt_valid, 1'b0);
            if (press_fb2) begin
                FB2 = 1'b0;
                tick();
                FB2 = 1'b1;
            end
            repeat (4) tick();
            if (mode != 1) begin
                if (mode == 2) car_floor = (e.floor == 2'd3) ? 2'd1 : 2'd3;
                else           car_floor = e.floor;
                arrive = 1'b1;
                tick();
                arrive = 1'b0;
            end
        end else begin
            idx = int'(e.floor) - 1;
            chk("pend_at_door", pend[idx], 1'b1);
            repeat (2) tick();
            chk("door_hold", door_req, 1'b1);
            door_done = 1'b1;
            tick();
            door_done = 1'b0;
            chk("door_drop", door_req, 1'b0);
            chk("pend_clr", pend[idx], 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        {FB1, FB2, FB3, CALL1, CALL2, CALL3} = '1;
        car_floor = 2'd1;
        {arrive, tgt_ack, door_done} = '0;
        tick();
        tick();
        chk_reset_vals("por");
        reset = 1'b0;
        tick();

        // Floor 1 to 3 with no intermediate stop
        push_ev(1'b0, 2'd2, 1'b1, 1'b1);
        push_ev(1'b0, 2'd3, 1'b1, 1'b1);
        push_ev(1'b1, 2'd3, 1'b0, 1'b0);
        CALL3 = 1'b0;
        tick();
        CALL3 = 1'b1;
        chk("pend_lat_n", pend, 3'b000);
        tick();
        chk("pend_lat_n1", pend, 3'b000);
        tick();
        chk("pend_lat_n2", pend, 3'b100);
        chk("valid_lat_n2", tgt_valid, 1'b0);
        tick();
        chk("valid_lat_n3", tgt_valid, 1'b1);
        expect_next(0, 1'b0);
        expect_next(0, 1'b0);
        expect_next(0, 1'b0);
        chk("t1_pend_empty", pend, 3'b000);
        arrive  = 1'b1;
        tgt_ack = 1'b1;
        tick();
        {arrive, tgt_ack} = '0;
        tick();
        chk("ignored_valid", tgt_valid, 1'b0);
        chk("ignored_fault", fault, 1'b0);

        // Intermediate stop collected on the way up
        do_reset(2'd1);
        push_ev(1'b0, 2'd2, 1'b1, 1'b1);
        push_ev(1'b1, 2'd2, 1'b1, 1'b1);
        push_ev(1'b0, 2'd3, 1'b1, 1'b1);
        push_ev(1'b1, 2'd3, 1'b0, 1'b0);
        CALL3 = 1'b0;
        tick();
        CALL3 = 1'b1;
        expect_next(0, 1'b1);
        expect_next(0, 1'b0);
        chk("t2_pend_remain", pend, 3'b100);
        expect_next(0, 1'b0);
        expect_next(0, 1'b0);

        // Direction reversal at floor 2 with only a lower request
        do_reset(2'd2);
        push_ev(1'b0, 2'd1, 1'b1, 1'b0);
        push_ev(1'b1, 2'd1, 1'b0, 1'b0);
        FB1 = 1'b0;
        tick();
        FB1 = 1'b1;
        expect_next(0, 1'b0);
        expect_next(0, 1'b0);

        // Held hall call re-sets the request after service
        push_ev(1'b0, 2'd2, 1'b1, 1'b1);
        push_ev(1'b1, 2'd2, 1'b0, 1'b0);
        push_ev(1'b1, 2'd2, 1'b0, 1'b0);
        CALL2 = 1'b0;
        expect_next(0, 1'b0);
        expect_next(0, 1'b0);
        tick();
        chk("held_reset_pend", pend[1], 1'b1);
        CALL2 = 1'b1;
        expect_next(0, 1'b0);
        repeat (3) tick();
        chk("held_done_pend", pend, 3'b000);
        chk("held_done_quiet", tgt_valid | door_req, 1'b0);

        // Travel watchdog
        push_ev(1'b0, 2'd3, 1'b1, 1'b1);
        FB3 = 1'b0;
        tick();
        FB3 = 1'b1;
        expect_next(1, 1'b0);
        repeat (195) tick();
        chk("wd_early", fault, 1'b0);
        tick();
        chk("wd_fault", fault, 1'b1);
        chk("wd_valid", tgt_valid, 1'b0);
        chk("wd_door", door_req, 1'b0);
        FB1 = 1'b0;
        tick();
        FB1 = 1'b1;
        tick();
        tick();
        chk("fault_pend_capture", pend, 3'b101);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("async");
        tick();
        reset = 1'b0;

        // Illegal floor code while idle
        do_reset(2'd0);
        tick();
        chk("floor0_fault", fault, 1'b1);

        // Arrival at a floor other than the target
        do_reset(2'd1);
        push_ev(1'b0, 2'd2, 1'b1, 1'b1);
        FB2 = 1'b0;
        tick();
        FB2 = 1'b1;
        expect_next(2, 1'b0);
        chk("mismatch_fault", fault, 1'b1);

`ifdef ELEV_IDLE_HOME_EN
        do_reset(2'd3);
        push_ev(1'b0, 2'd2, 1'b1, 1'b0);
        push_ev(1'b0, 2'd1, 1'b1, 1'b0);
        repeat (60) tick();
        chk("home_wait", tgt_valid, 1'b0);
        expect_next(0, 1'b0);
        expect_next(0, 1'b0);
        repeat (10) tick();
        chk("home_no_door", door_req | tgt_valid, 1'b0);
`else
        do_reset(2'd3);
        repeat (100) tick();
        chk("park_idle", tgt_valid | door_req, 1'b0);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
